// File: rtl/wb_arbiter_pkg.sv
// Shared state and grant encodings for the 2:1 Wishbone arbiter.
package wb_arbiter_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned GRANT_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] OWN0 = 2'd1;
  localparam logic [STATE_W-1:0] OWN1 = 2'd2;

  localparam logic [GRANT_W-1:0] GRANT_IDLE = 2'b00;
  localparam logic [GRANT_W-1:0] GRANT_M0   = 2'b01;
  localparam logic [GRANT_W-1:0] GRANT_M1   = 2'b10;

  // One-hot owner encoding of a state value.
  function automatic logic [GRANT_W-1:0] grant_of(input logic [STATE_W-1:0] st);
    case (st)
      OWN0:    return GRANT_M0;
      OWN1:    return GRANT_M1;
      default: return GRANT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone bus bundle with master/slave views.
interface wb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_timeout.sv
// Stall watchdog: counts unanswered strobe cycles and issues a one-cycle timeout pulse.
module wb_arbiter_timeout
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic own_change,
  output logic timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stall_c;
  logic             fire_c;

  assign stall_c = stb & ~ack & ~err;
  // The stall that brings the count to TIMEOUT_CYCLES fires the pulse for the next cycle.
  assign fire_c  = stall_c & ~own_change & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter and registered timeout pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= fire_c;
      if (!stall_c || own_change || fire_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-master, one-slave Wishbone arbiter with round-robin on contention.
// Optional stall watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter_2x1
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rstn,
  wb_if.slave                m0,
  wb_if.slave                m1,
  wb_if.master               s,
  output logic [GRANT_W-1:0] grant_o,
  output logic               timeout_o
);

  state_t state_q;
  state_t state_d;
  logic   last_q;   // 1: m1 was granted last, so m0 wins the next tie
  logic   last_d;
  logic   force_err_c;
  logic   unused_c;

  // State, round-robin pointer and registered grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_o <= GRANT_IDLE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_o <= grant_of(state_d);
    end
  end

  // Next-state: hold owner while its cyc is high, hand over directly on release.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0.cyc) begin
          state_d = OWN0;
        end else if (m1.cyc) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0.cyc) begin
          state_d = m1.cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1.cyc) begin
          state_d = m0.cyc ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == OWN0) begin
      last_d = 1'b0;
    end else if (state_d == OWN1) begin
      last_d = 1'b1;
    end
  end

  // Request mux to the slave and response routing back to the owner only.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.sel    = '0;
    s.adr    = '0;
    s.dat_w  = '0;
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.dat_r = '0;
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.dat_r = '0;
    case (state_q)
      OWN0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.sel    = m0.sel;
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        m0.ack   = s.ack & m0.cyc;
        m0.err   = s.err | force_err_c;
        m0.dat_r = s.dat_r;
      end
      OWN1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.sel    = m1.sel;
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        m1.ack   = s.ack & m1.cyc;
        m1.err   = s.err | force_err_c;
        m1.dat_r = s.dat_r;
      end
      default: ;
    endcase
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  wb_arbiter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rstn      (rstn),
    .stb       (s.stb),
    .ack       (s.ack),
    .err       (s.err),
    .own_change(state_d != state_q),
    .timeout_o (timeout_o)
  );
  assign force_err_c = timeout_o;
  assign unused_c    = ^{32'(WB_ADDR_WIDTH), 32'(WB_DATA_WIDTH)};
`else
  assign timeout_o   = 1'b0;
  assign force_err_c = 1'b0;
  assign unused_c    = ^{32'(WB_ADDR_WIDTH), 32'(WB_DATA_WIDTH), 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Self-checking bench for wb_arbiter_2x1: directed scenarios plus randomized traffic
// checked every cycle against an ownership/round-robin/watchdog model.
module tb_wb_arbiter_2x1;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rstn;
  logic [1:0] grant_o;
  logic timeout_o;

  int checks = 0;
  int failures = 0;

  // model: owner 0=none 1=m0 2=m1; prefer 0 means m0 wins the next tie
  int owner = 0;
  int prefer = 0;
  int run = 0;
  bit pend = 1'b0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;

  wb_if #(.AW(AW), .DW(DW)) m0_if ();
  wb_if #(.AW(AW), .DW(DW)) m1_if ();
  wb_if #(.AW(AW), .DW(DW)) s_if ();

  wb_arbiter_2x1 #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin : cmp
    logic [1:0]  exp_g;
    logic        oc, os, ow;
    logic [3:0]  osel;
    logic [31:0] oadr, odat;
    logic        stall;
    int          nxt;
    if (!rstn) begin
      owner = 0; prefer = 0; run = 0; pend = 1'b0;
    end
    exp_g = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    oc = 1'b0; os = 1'b0; ow = 1'b0; osel = '0; oadr = '0; odat = '0;
    if (owner == 1) begin
      oc = m0_if.cyc; os = m0_if.stb; ow = m0_if.we; osel = m0_if.sel; oadr = m0_if.adr; odat = m0_if.dat_w;
    end else if (owner == 2) begin
      oc = m1_if.cyc; os = m1_if.stb; ow = m1_if.we; osel = m1_if.sel; oadr = m1_if.adr; odat = m1_if.dat_w;
    end
    chk("grant", 64'(grant_o), 64'(exp_g));
    chk("timeout", 64'(timeout_o), 64'(pend));
    chk("s_cyc", 64'(s_if.cyc), 64'(oc));
    chk("s_stb", 64'(s_if.stb), 64'(os));
    if (owner != 0) begin
      chk("s_we", 64'(s_if.we), 64'(ow));
      chk("s_sel", 64'(s_if.sel), 64'(osel));
      chk("s_adr", 64'(s_if.adr), 64'(oadr));
      chk("s_dat_w", 64'(s_if.dat_w), 64'(odat));
    end
    chk("m0_ack", 64'(m0_if.ack), (owner == 1) ? 64'(s_if.ack & m0_if.cyc) : 64'(0));
    chk("m1_ack", 64'(m1_if.ack), (owner == 2) ? 64'(s_if.ack & m1_if.cyc) : 64'(0));
    chk("m0_err", 64'(m0_if.err), (owner == 1) ? 64'(s_if.err | pend) : 64'(0));
    chk("m1_err", 64'(m1_if.err), (owner == 2) ? 64'(s_if.err | pend) : 64'(0));
    chk("m0_dat_r", 64'(m0_if.dat_r), (owner == 1) ? 64'(s_if.dat_r) : 64'(0));
    chk("m1_dat_r", 64'(m1_if.dat_r), (owner == 2) ? 64'(s_if.dat_r) : 64'(0));
    if (m0_if.ack) ack_cnt0++;
    if (m1_if.ack) ack_cnt1++;
    if (rstn) begin
      if (owner == 0) begin
        if (m0_if.cyc && m1_if.cyc) nxt = (prefer == 0) ? 1 : 2;
        else if (m0_if.cyc) nxt = 1;
        else if (m1_if.cyc) nxt = 2;
        else nxt = 0;
      end else if (owner == 1) begin
        nxt = m0_if.cyc ? 1 : (m1_if.cyc ? 2 : 0);
      end else begin
        nxt = m1_if.cyc ? 2 : (m0_if.cyc ? 1 : 0);
      end
      if (nxt == 1) prefer = 1;
      if (nxt == 2) prefer = 0;
      stall = (owner != 0) && os && !s_if.ack && !s_if.err;
`ifdef WB_ARBITER_TIMEOUT_EN
      if (nxt != owner || !stall) begin
        run = 0; pend = 1'b0;
      end else begin
        run++;
        if (run == int'(TO)) begin pend = 1'b1; run = 0; end
        else pend = 1'b0;
      end
`else
      pend = 1'b0;
      if (stall) run = 0;
`endif
      owner = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.sel = '0; m0_if.adr = '0; m0_if.dat_w = '0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.sel = '0; m1_if.adr = '0; m1_if.dat_w = '0;
    s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = '0;
  endtask

  task automatic reset_dut();
    step();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic rand_master(inout logic cyc, inout logic stb, inout logic we,
                             inout logic [3:0] sel, inout logic [31:0] adr, inout logic [31:0] dat);
    if (cyc) begin
      if ($urandom_range(0, 15) == 0) cyc = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      cyc = 1'b1;
    end
    stb = cyc && ($urandom_range(0, 7) != 0);
    we  = 1'($urandom_range(0, 1));
    sel = 4'($urandom_range(0, 15));
    adr = $urandom;
    dat = $urandom;
  endtask

  initial begin : main
    int first_to;
    int first_err;
    int dead;
    rstn = 1'b0;
    clear_inputs();
    repeat (3) step();
    chk("reset_grant", 64'(grant_o), 64'(2'b00));
    chk("reset_timeout", 64'(timeout_o), 64'(1'b0));
    chk("reset_s_cyc", 64'(s_if.cyc), 64'(1'b0));
    rstn = 1'b1;

    // m1 alone, slave acks after two wait cycles
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h1000_0004; m1_if.sel = 4'hf;
    ack_cnt0 = 0; ack_cnt1 = 0;
    chk("r35_grant_c0", 64'(grant_o), 64'(2'b00));
    step();
    chk("r35_grant_c1", 64'(grant_o), 64'(2'b10));
    #2 chk("r35_adr", 64'(s_if.adr), 64'(32'h1000_0004));
    step();
    step();
    s_if.ack = 1'b1; s_if.dat_r = 32'hcafe_0035;
    #2 chk("r35_m1_dat", 64'(m1_if.dat_r), 64'(32'hcafe_0035));
    chk("r35_m0_dat", 64'(m0_if.dat_r), 64'(0));
    step();
    s_if.ack = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
    step();
    chk("r35_m1_acks", 64'(ack_cnt1), 64'(1));
    chk("r35_m0_acks", 64'(ack_cnt0), 64'(0));
    chk("r35_idle", 64'(grant_o), 64'(2'b00));

    // simultaneous requests after reset, direct handover, then round-robin
    reset_dut();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    chk("r36_first_m0", 64'(grant_o), 64'(2'b01));
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
    chk("r36_switch_m1", 64'(grant_o), 64'(2'b10));
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
    chk("r36_idle", 64'(grant_o), 64'(2'b00));
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    step();
    chk("r36_m0_alone", 64'(grant_o), 64'(2'b01));
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    chk("r36_repeat_m1", 64'(grant_o), 64'(2'b10));
    clear_inputs();
    step();

    // no pre-emption during three acked beats
    reset_dut();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    ack_cnt0 = 0; ack_cnt1 = 0;
    step();
    for (int b = 0; b < 3; b++) begin
      s_if.ack = 1'b1;
      chk("r37_hold_m0", 64'(grant_o), 64'(2'b01));
      step();
    end
    s_if.ack = 1'b0; m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    chk("r37_still_m0", 64'(grant_o), 64'(2'b01));
    step();
    chk("r37_m1_next", 64'(grant_o), 64'(2'b10));
    chk("r37_m0_beats", 64'(ack_cnt0), 64'(3));
    chk("r37_m1_acks", 64'(ack_cnt1), 64'(0));
    clear_inputs();
    step();

    // slave never answers
    reset_dut();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    first_to = -1; first_err = -1;
    step();
    for (int k = 0; k < 12; k++) begin
      #2;
      if (timeout_o && first_to < 0) first_to = k;
      if (m0_if.err && first_err < 0) first_err = k;
      step();
    end
`ifdef WB_ARBITER_TIMEOUT_EN
    chk("r38_timeout_cycle", 64'(first_to), 64'(8));
    chk("r38_err_cycle", 64'(first_err), 64'(8));
`else
    chk("r38_no_timeout", 64'(first_to), 64'(-1));
    chk("r38_no_err", 64'(first_err), 64'(-1));
`endif
    clear_inputs();
    step();

    // reset during an OWN1 wait state
    reset_dut();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    chk("r39_own1", 64'(grant_o), 64'(2'b10));
    step();
    #2 rstn = 1'b0; s_if.ack = 1'b1;
    #1;
    chk("r39_s_cyc", 64'(s_if.cyc), 64'(1'b0));
    chk("r39_s_stb", 64'(s_if.stb), 64'(1'b0));
    chk("r39_grant", 64'(grant_o), 64'(2'b00));
    chk("r39_m1_ack", 64'(m1_if.ack), 64'(1'b0));
    step();
    rstn = 1'b1; s_if.ack = 1'b0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    step();
    chk("r39_after_m0", 64'(grant_o), 64'(2'b01));
    clear_inputs();
    step();

    // ack in the cycle the owner drops cyc, other master waiting
    reset_dut();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    step();
    step();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; s_if.ack = 1'b1;
    #2 chk("r40_m0_ack", 64'(m0_if.ack), 64'(1'b0));
    chk("r40_m1_ack", 64'(m1_if.ack), 64'(1'b0));
    step();
    s_if.ack = 1'b0;
    chk("r40_switch", 64'(grant_o), 64'(2'b10));
    clear_inputs();
    step();

    // randomized traffic, checked by the per-cycle model
    reset_dut();
    dead = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      rstn = ($urandom_range(0, 799) != 0);
      rand_master(m0_if.cyc, m0_if.stb, m0_if.we, m0_if.sel, m0_if.adr, m0_if.dat_w);
      rand_master(m1_if.cyc, m1_if.stb, m1_if.we, m1_if.sel, m1_if.adr, m1_if.dat_w);
      if (dead > 0) begin
        dead--;
        s_if.ack = 1'b0; s_if.err = 1'b0;
      end else begin
        if ($urandom_range(0, 99) == 0) dead = 12;
        s_if.ack = ($urandom_range(0, 2) == 0);
        s_if.err = !s_if.ack && ($urandom_range(0, 19) == 0);
      end
      s_if.dat_r = $urandom;
    end
    step();
    rstn = 1'b1;
    clear_inputs();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
